// File: rtl/dmem_wait_ctrl_if.sv
// dmem_wait_ctrl_if: CPU data-port bundle between the pipeline and the wait-state memory controller.
interface dmem_wait_ctrl_if #(parameter int CNT_W = 16);
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic             sign_ext;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             stall;
    logic             done;
    logic             addr_err;
    logic [CNT_W-1:0] access_cnt;
    modport master (output req, we, size, sign_ext, addr, wdata,
                    input  rdata, stall, done, addr_err, access_cnt);
    modport slave  (input  req, we, size, sign_ext, addr, wdata,
                    output rdata, stall, done, addr_err, access_cnt);
endinterface

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: byte/half/word data memory with wait states, stall handshake, misalign detection and access counter.
module dmem_wait_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             rst,
    dmem_wait_ctrl_if.slave bus
);
    localparam int LM1 = (LATENCY > 0) ? LATENCY - 1 : 0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state, nxt;
    logic [2:0]        cnt;
    logic              l_we, l_sx, l_err;
    logic [1:0]        l_size;
    logic [ADDR_W+1:0] l_addr;
    logic [31:0]       l_wdata;
    logic              c_we, c_sx, c_err, good;
    logic [1:0]        c_size;
    logic [ADDR_W+1:0] c_addr;
    logic [31:0]       c_wdata, wd, word, lane, ld;
    logic [3:0]        be;
    logic [CNT_W-1:0]  acnt;
    logic [31:0]       rdata;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    // In IDLE the access is being latched on this same edge, so use the live bus values.
    always_comb begin
        c_we    = (state == IDLE) ? bus.we : l_we;
        c_sx    = (state == IDLE) ? bus.sign_ext : l_sx;
        c_size  = (state == IDLE) ? bus.size : l_size;
        c_addr  = (state == IDLE) ? bus.addr[ADDR_W+1:0] : l_addr;
        c_wdata = (state == IDLE) ? bus.wdata : l_wdata;
        c_err   = (c_size == 2'b11) | (c_size == 2'b01 & c_addr[0]) | (c_size == 2'b10 & |c_addr[1:0]);
        good    = (nxt == RESP) & (state != RESP) & ~c_err & ~rst;
        be      = (c_size == 2'b00) ? 4'b0001 << c_addr[1:0] :
                  (c_size == 2'b01) ? 4'b0011 << {c_addr[1], 1'b0} : 4'b1111;
        wd      = (c_size == 2'b00) ? {4{c_wdata[7:0]}} :
                  (c_size == 2'b01) ? {2{c_wdata[15:0]}} : c_wdata;
        word    = mem[c_addr[ADDR_W+1:2]];
        lane    = word >> {c_addr[1:0], 3'b000};
        ld      = (c_size == 2'b00) ? {{24{c_sx & lane[7]}}, lane[7:0]} :
                  (c_size == 2'b01) ? {{16{c_sx & lane[15]}}, lane[15:0]} : word;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;
    always_comb
        nxt = (state == IDLE) ? (bus.req ? ((c_err || LATENCY == 0) ? RESP : WAIT) : IDLE) :
              (state == WAIT) ? ((cnt == 3'd0) ? RESP : WAIT) : IDLE;
    always_comb begin
        bus.done       = (state == RESP);
        bus.addr_err   = (state == RESP) & l_err;
        bus.stall      = bus.req & (state != RESP) & ~rst;
        bus.rdata      = rdata;
        bus.access_cnt = acnt;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt     <= '0;
            l_we    <= 1'b0;
            l_sx    <= 1'b0;
            l_err   <= 1'b0;
            l_size  <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
            acnt    <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                cnt     <= 3'(LM1);
                l_we    <= bus.we;
                l_sx    <= bus.sign_ext;
                l_err   <= c_err;
                l_size  <= bus.size;
                l_addr  <= bus.addr[ADDR_W+1:0];
                l_wdata <= bus.wdata;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (good && !c_we) rdata <= ld;
            if (good && !(&acnt)) acnt <= acnt + 1'b1;
        end
    // Storage is never reset; writes are gated by rst so a store interrupted by reset is dropped.
    always_ff @(posedge clk)
        if (good && c_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[ADDR_W+1:2]][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: two controllers (LATENCY=2/CNT_W=16 and LATENCY=0/CNT_W=4) against a word-array reference model.
module tb_dmem_wait_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dmem_wait_ctrl_if #(.CNT_W(16)) ia ();
    dmem_wait_ctrl_if #(.CNT_W(4))  ib ();
    dmem_wait_ctrl #(.ADDR_W(10), .DATA_W(32), .LATENCY(2), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    dmem_wait_ctrl #(.ADDR_W(10), .DATA_W(32), .LATENCY(0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    logic        req_v [2];
    logic        we_v  [2];
    logic        sx_v  [2];
    logic [1:0]  sz_v  [2];
    logic [31:0] ad_v  [2];
    logic [31:0] wd_v  [2];
    logic [31:0] rd    [2];
    logic        st    [2];
    logic        dn    [2];
    logic        er    [2];
    logic [15:0] cn    [2];
    assign ia.req = req_v[0];  assign ia.we = we_v[0];  assign ia.sign_ext = sx_v[0];
    assign ia.size = sz_v[0];  assign ia.addr = ad_v[0]; assign ia.wdata = wd_v[0];
    assign ib.req = req_v[1];  assign ib.we = we_v[1];  assign ib.sign_ext = sx_v[1];
    assign ib.size = sz_v[1];  assign ib.addr = ad_v[1]; assign ib.wdata = wd_v[1];
    assign rd[0] = ia.rdata;  assign st[0] = ia.stall;  assign dn[0] = ia.done;
    assign er[0] = ia.addr_err; assign cn[0] = ia.access_cnt;
    assign rd[1] = ib.rdata;  assign st[1] = ib.stall;  assign dn[1] = ib.done;
    assign er[1] = ib.addr_err; assign cn[1] = {12'b0, ib.access_cnt};
    logic [31:0] mdl [2][1024];
    logic [31:0] exp_rd [2];
    int exp_cnt [2];
    int lat  [2] = '{2, 0};
    int cmax [2] = '{65535, 15};
    int checks = 0;
    int errors = 0;
    function automatic logic [31:0] load(logic [31:0] w, logic [1:0] sz, bit sx, logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        if (sz == 2'b10) return w;
        if (sz == 2'b01) return sx ? {{16{h[15]}}, h} : {16'b0, h};
        return sx ? {{24{b[7]}}, b} : {24'b0, b};
    endfunction
    task automatic access(int d, bit w, bit [1:0] sz, bit sx, bit [31:0] a, bit [31:0] wd, bit keep);
        bit          err;
        int          el;
        logic [31:0] word;
        req_v[d] = 1'b1; we_v[d] = w; sz_v[d] = sz; sx_v[d] = sx; ad_v[d] = a; wd_v[d] = wd;
        err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        el  = err ? 0 : lat[d];
        if (!err) begin
            word = mdl[d][a[11:2]];
            if (w) begin
                if (sz == 2'b00) word[8*a[1:0] +: 8] = wd[7:0];
                else if (sz == 2'b01) word[16*a[1] +: 16] = wd[15:0];
                else word = wd;
                mdl[d][a[11:2]] = word;
            end else exp_rd[d] = load(word, sz, sx, a[1:0]);
            if (exp_cnt[d] < cmax[d]) exp_cnt[d]++;
        end
        #1;
        for (int c = 0; c <= el; c++) begin
            checks++;
            if (st[d] !== 1'b1 || dn[d] !== 1'b0 || er[d] !== 1'b0) begin
                errors++;
                $display("FAIL wait d%0d cycle %0d a=%h: stall/done/err=%b%b%b required 100", d, c, a, st[d], dn[d], er[d]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (st[d] !== 1'b0 || dn[d] !== 1'b1 || er[d] !== err) begin
            errors++;
            $display("FAIL done d%0d a=%h: stall/done/err=%b%b%b required 01%b", d, a, st[d], dn[d], er[d], err);
        end
        checks++;
        if (rd[d] !== exp_rd[d]) begin
            errors++;
            $display("FAIL rdata d%0d a=%h sz=%0d: got %h required %h", d, a, sz, rd[d], exp_rd[d]);
        end
        checks++;
        if (cn[d] !== 16'(exp_cnt[d])) begin
            errors++;
            $display("FAIL access_cnt d%0d: got %0d required %0d", d, cn[d], exp_cnt[d]);
        end
        if (!keep) req_v[d] = 1'b0;
        @(posedge clk); #1;
        if (!keep) begin
            checks++;
            if (dn[d] !== 1'b0 || st[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle d%0d: done/stall=%b%b required 00", d, dn[d], st[d]);
            end
        end
    endtask
    task automatic check_zero(string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd[d] !== 32'h0 || dn[d] !== 1'b0 || er[d] !== 1'b0 || cn[d] !== 16'h0 || st[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s d%0d: rdata=%h done=%b err=%b cnt=%0d stall=%b required all 0", tag, d, rd[d], dn[d], er[d], cn[d], st[d]);
            end
        end
    endtask
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; sx_v[d] = 1'b0; sz_v[d] = 2'b0; ad_v[d] = '0; wd_v[d] = '0;
            exp_rd[d] = '0; exp_cnt[d] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask
    task automatic test_word_access();
        access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        access(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        checks++;
        if (rd[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_load: got %h required deadbeef", rd[0]);
        end
    endtask
    task automatic test_byte_ext();
        access(0, 1, 2'b10, 0, 32'h10, 32'h0, 0);
        access(0, 1, 2'b00, 0, 32'h13, 32'h80, 0);
        access(0, 0, 2'b00, 1, 32'h13, 32'h0, 0);
        checks++;
        if (rd[0] !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed: got %h required ffffff80", rd[0]); end
        access(0, 0, 2'b00, 0, 32'h13, 32'h0, 0);
        checks++;
        if (rd[0] !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned: got %h required 00000080", rd[0]); end
        access(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
        checks++;
        if (rd[0] !== 32'h80000000) begin errors++; $display("FAIL byte_word: got %h required 80000000", rd[0]); end
    endtask
    task automatic test_errors();
        access(0, 0, 2'b01, 1, 32'h11, 32'h0, 0);
        access(0, 0, 2'b11, 0, 32'h10, 32'h0, 0);
        access(0, 1, 2'b10, 0, 32'h12, 32'h12345678, 0);
        access(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    endtask
    task automatic test_back_to_back();
        access(1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 1);
        access(1, 0, 2'b10, 0, 32'h1010, 32'h0, 0);
        checks++;
        if (rd[1] !== 32'hCAFEF00D || cn[1] !== 16'd2) begin
            errors++;
            $display("FAIL back_to_back alias: rdata=%h cnt=%0d required cafef00d/2", rd[1], cn[1]);
        end
    endtask
    task automatic test_reset_mid();
        access(0, 1, 2'b10, 0, 32'h40, 32'h11223344, 0);
        req_v[0] = 1'b1; we_v[0] = 1'b1; sz_v[0] = 2'b10; ad_v[0] = 32'h40; wd_v[0] = 32'h99887766;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_zero("reset_mid");
        @(posedge clk); #1;
        check_zero("reset_hold");
        rst = 1'b0;
        req_v[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin exp_rd[d] = '0; exp_cnt[d] = 0; end
        @(posedge clk); #1;
        checks++;
        if (dn[0] !== 1'b0) begin errors++; $display("FAIL reset_no_done: done=%b required 0", dn[0]); end
        access(0, 0, 2'b10, 0, 32'h40, 32'h0, 0);
        checks++;
        if (rd[0] !== 32'h11223344) begin errors++; $display("FAIL reset_storage: got %h required 11223344", rd[0]); end
    endtask
    task automatic test_random(int d, int n);
        for (int k = 0; k < 8; k++) access(d, 1, 2'b10, 0, 32'h100 + 32'(4*k), $urandom, 0);
        for (int k = 0; k < n; k++)
            access(d, 1'($urandom), 2'($urandom), 1'($urandom),
                   ($urandom & 32'hFFFFF000) | 32'h100 | 32'($urandom_range(0, 31)), $urandom, 0);
    endtask
    task automatic test_saturation();
        for (int k = 0; k < 17; k++) access(1, 0, 2'b10, 0, 32'h100, 32'h0, 0);
        checks++;
        if (cn[1] !== 16'd15) begin errors++; $display("FAIL saturation: got %0d required 15", cn[1]); end
    endtask
    initial begin
        test_reset();
        test_word_access();
        test_byte_ext();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 60);
        test_random(1, 60);
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
